datapath_exec: RTL

DATAPATH_EXEC -- requirements
Module: datapath_exec

---
 rtl/datapath_exec_pkg.sv | 50 +++++
 rtl/datapath_exec_block_scan.sv | 68 ++++++
 rtl/datapath_exec.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/datapath_exec_pkg.sv
// Shared constants for the datapath executor: instruction field layout, opcodes,
// bus widths, screen and block geometry, and the controller state encoding.
package datapath_exec_pkg;

   localparam int INSTRUCTION_WIDTH = 32;
   localparam int RESULT_WIDTH      = 16;
   localparam int MEM_ADDR_WIDTH    = 16;
   localparam int MEM_DATA_WIDTH    = 16;
   localparam int X_COORD_WIDTH     = 8;
   localparam int Y_COORD_WIDTH     = 7;
   localparam int COLOUR_WIDTH      = 3;

   localparam int SCREEN_WIDTH  = 160;
   localparam int SCREEN_HEIGHT = 120;
   localparam int BLOCK_WIDTH   = 4;
   localparam int BLOCK_HEIGHT  = 4;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int DATA_MSB   = 27;
   localparam int DATA_LSB   = 16;
   localparam int ADDR_MSB   = 15;
   localparam int ADDR_LSB   = 0;
   localparam int PLOT_BIT   = 18;
   localparam int COLOUR_MSB = 17;
   localparam int COLOUR_LSB = 15;
   localparam int Y_MSB      = 14;
   localparam int Y_LSB      = 8;
   localparam int X_MSB      = 7;
   localparam int X_LSB      = 0;

   localparam logic [RESULT_WIDTH-1:0] ILLEGAL_RESULT = 16'hFFFF;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_DRAW  = 4'd1,
      OP_LOAD  = 4'd2,
      OP_STORE = 4'd3
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_DRAW,
      S_LOAD_WAIT,
      S_LOAD_CAP,
      S_DONE
   } state_e;

endpackage

// File: rtl/datapath_exec_block_scan.sv
// Walks the pixel offsets of one block (x offset fastest) and produces the screen
// coordinate of the current pixel. Optional clipping: DATAPATH_CLIP_EN.
module datapath_exec_block_scan
   import datapath_exec_pkg::*;
#(
   parameter int BLOCK_W = BLOCK_WIDTH,
   parameter int BLOCK_H = BLOCK_HEIGHT
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic                     step,
   input  logic [X_COORD_WIDTH-1:0] base_x,
   input  logic [Y_COORD_WIDTH-1:0] base_y,
   output logic [X_COORD_WIDTH-1:0] pix_x,
   output logic [Y_COORD_WIDTH-1:0] pix_y,
   output logic                     visible,
   output logic                     done
);

   localparam int DX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
   localparam int DY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

   logic [DX_W-1:0] dx;
   logic [DY_W-1:0] dy;
   logic            dx_last;
   logic            last;

   assign dx_last = (dx == DX_W'(BLOCK_W - 1));
   assign last    = dx_last && (dy == DY_W'(BLOCK_H - 1));

   // done marks that the final offset has been handed out; it stays set until cleared.
   always_ff @(posedge clock) begin
      if (!resetn || clear) begin
         dx   <= '0;
         dy   <= '0;
         done <= 1'b0;
      end else if (step) begin
         if (last) begin
            dx   <= '0;
            dy   <= '0;
            done <= 1'b1;
         end else if (dx_last) begin
            dx <= '0;
            dy <= dy + 1'b1;
         end else begin
            dx <= dx + 1'b1;
         end
      end
   end

`ifdef DATAPATH_CLIP_EN
   logic [X_COORD_WIDTH:0] sum_x;
   logic [Y_COORD_WIDTH:0] sum_y;

   assign sum_x   = {1'b0, base_x} + (X_COORD_WIDTH + 1)'(dx);
   assign sum_y   = {1'b0, base_y} + (Y_COORD_WIDTH + 1)'(dy);
   assign pix_x   = sum_x[X_COORD_WIDTH-1:0];
   assign pix_y   = sum_y[Y_COORD_WIDTH-1:0];
   assign visible = (sum_x < (X_COORD_WIDTH + 1)'(SCREEN_WIDTH)) &&
                    (sum_y < (Y_COORD_WIDTH + 1)'(SCREEN_HEIGHT));
`else
   assign pix_x   = base_x + X_COORD_WIDTH'(dx);
   assign pix_y   = base_y + Y_COORD_WIDTH'(dy);
   assign visible = 1'b1;
`endif

endmodule

// File: rtl/datapath_exec.sv
// Single-issue executor for NOP / DRAW / LOAD / STORE instructions with a
// start/finished handshake. Optional clipping of drawn pixels: DATAPATH_CLIP_EN.
module datapath_exec
   import datapath_exec_pkg::*;
#(
   parameter int BLOCK_W = BLOCK_WIDTH,
   parameter int BLOCK_H = BLOCK_HEIGHT
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         finished,
   output logic [RESULT_WIDTH-1:0]      result,
   output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
   output logic [MEM_DATA_WIDTH-1:0]    mem_wdata,
   output logic                         mem_we,
   input  logic [MEM_DATA_WIDTH-1:0]    mem_rdata,
   output logic [X_COORD_WIDTH-1:0]     vga_x,
   output logic [Y_COORD_WIDTH-1:0]     vga_y,
   output logic [COLOUR_WIDTH-1:0]      vga_colour,
   output logic                         vga_plot
);

   state_e                         state, state_nxt;
   logic [INSTRUCTION_WIDTH-1:0]   instr_q;
   logic                           start_q;
   logic                           accept;
   logic [3:0]                     opcode;
   logic                           plot_req;
   logic [MEM_DATA_WIDTH-1:0]      store_data;
   logic                           scan_step;
   logic [X_COORD_WIDTH-1:0]       scan_x;
   logic [Y_COORD_WIDTH-1:0]       scan_y;
   logic                           scan_visible;
   logic                           scan_done;

   // start_q resets high so a start held through reset is not taken as a new request.
   assign accept     = (state == S_IDLE) && start && !start_q;
   assign opcode     = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign plot_req   = instr_q[PLOT_BIT];
   assign store_data = MEM_DATA_WIDTH'(instr_q[DATA_MSB:DATA_LSB]);
   assign scan_step  = ((state == S_DECODE) && (opcode == OP_DRAW) && plot_req) ||
                       ((state == S_DRAW) && !scan_done);

   datapath_exec_block_scan #(
      .BLOCK_W (BLOCK_W),
      .BLOCK_H (BLOCK_H)
   ) u_block_scan (
      .clock   (clock),
      .resetn  (resetn),
      .clear   (state == S_IDLE),
      .step    (scan_step),
      .base_x  (instr_q[X_MSB:X_LSB]),
      .base_y  (instr_q[Y_MSB:Y_LSB]),
      .pix_x   (scan_x),
      .pix_y   (scan_y),
      .visible (scan_visible),
      .done    (scan_done)
   );

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state   <= S_IDLE;
         start_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         start_q <= start;
      end
   end

   // NOTE: the default assignment up front keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (accept) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD: state_nxt = S_LOAD_WAIT;
               OP_DRAW: state_nxt = plot_req ? S_DRAW : S_DONE;
               default: state_nxt = S_DONE;
            endcase
         end
         S_DRAW:      if (scan_done) state_nxt = S_DONE;
         S_LOAD_WAIT: state_nxt = S_LOAD_CAP;
         S_LOAD_CAP:  state_nxt = S_IDLE;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs; the write and plot strobes fall by default each cycle.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         instr_q    <= '0;
         finished   <= 1'b1;
         result     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         mem_we   <= 1'b0;
         vga_plot <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  instr_q  <= instruction;
                  finished <= 1'b0;
               end
            end
            S_DECODE: begin
               if (opcode == OP_STORE) begin
                  mem_addr  <= instr_q[ADDR_MSB:ADDR_LSB];
                  mem_wdata <= store_data;
                  mem_we    <= 1'b1;
               end else if (opcode == OP_LOAD) begin
                  mem_addr <= instr_q[ADDR_MSB:ADDR_LSB];
               end
            end
            S_LOAD_CAP: begin
               result   <= mem_rdata;
               finished <= 1'b1;
            end
            S_DONE: begin
               finished <= 1'b1;
               case (opcode)
                  OP_NOP, OP_DRAW: result <= '0;
                  OP_STORE:        result <= store_data;
                  default:         result <= ILLEGAL_RESULT;
               endcase
            end
            default: ;
         endcase
         if (scan_step) begin
            vga_x      <= scan_x;
            vga_y      <= scan_y;
            vga_colour <= instr_q[COLOUR_MSB:COLOUR_LSB];
            vga_plot   <= scan_visible;
         end
      end
   end

endmodule
